// File: rtl/data_mem_resp.sv
// data_mem_resp: word RAM, led register and cycle counter behind
// a fixed-latency request / single-cycle response handshake.
module data_mem_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [7:0]  led
);

    localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] CYC_ADDR = 32'hFFFF_FF04;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LD  =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_wait;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_rd;
    logic                r_wr;
    logic                r_err;
    logic [31:0]         r_cyc;
    logic [31:0]         r_mem [DEPTH];

    logic                w_req;
    logic                w_idle;
    logic                w_enter_resp;
    logic [31:0]         w_addr;
    logic [31:0]         w_wdata;
    logic                w_rd;
    logic                w_wr;
    logic                w_is_ram;
    logic                w_is_led;
    logic                w_is_cyc;
    logic                w_err;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_idx;

    assign w_req  = MemRead | MemWrite;
    assign w_idle = (r_state == S_IDLE);

    // With zero wait states the response edge is the acceptance edge,
    // so decode must look at the live inputs rather than the latches.
    assign w_addr  = w_idle ? mem_addr    : r_addr;
    assign w_wdata = w_idle ? mem_data_in : r_wdata;
    assign w_rd    = w_idle ? MemRead     : r_rd;
    assign w_wr    = w_idle ? MemWrite    : r_wr;

    assign w_is_ram = (w_addr[31:ADDR_W+2] == '0);
    assign w_is_led = (w_addr == LED_ADDR);
    assign w_is_cyc = (w_addr == CYC_ADDR);
    assign w_idx    = w_addr[ADDR_W+1:2];

    assign w_err = (w_rd & w_wr)
                 | (w_addr[1:0] != 2'b00)
                 | ~(w_is_ram | w_is_led | w_is_cyc);

    assign w_enter_resp = (w_next == S_RESP);

    // Gating with reset keeps a held request from writing while in reset.
    assign w_ram_we = w_enter_resp & ~w_err & w_wr & w_is_ram & reset;

    // State register.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Response strobe and error flag decoded from the state.
    always_comb begin
        mem_ready = (r_state == S_RESP);
        mem_err   = (r_state == S_RESP) & r_err;
    end

    // Latch the request and run the wait-state counter.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wait  <= '0;
        end else if (w_idle && w_req) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_data_in;
            r_rd    <= MemRead;
            r_wr    <= MemWrite;
            r_wait  <= WAIT_LD;
        end else if (r_state == S_WAIT && r_wait != 4'd0) begin
            r_wait  <= r_wait - 4'd1;
        end
    end

    // Read data, error flag and led update on the edge entering RESP.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_err        <= 1'b0;
            mem_data_out <= '0;
            led          <= '0;
        end else if (w_enter_resp) begin
            r_err <= w_err;
            if (w_err) begin
                mem_data_out <= ERR_DATA;
            end else if (w_rd) begin
                if (w_is_ram) begin
                    mem_data_out <= r_mem[w_idx];
                end else if (w_is_led) begin
                    mem_data_out <= {24'd0, led};
                end else begin
                    mem_data_out <= r_cyc;
                end
            end else if (w_is_led) begin
                led <= w_wdata[7:0];
            end
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
        end
    end

    // Word RAM, intentionally not cleared by reset.
    always_ff @(posedge cpu_clk) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait states inserted before each response (legal range 0..15).
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving log2 of the RAM depth in 32-bit words.
REQ-003 The block SHALL have port cpu_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_addr, input, 32 bits: byte address from the CPU, held stable while a request is pending.
REQ-006 The block SHALL have port mem_data_in, input, 32 bits: CPU write data, held stable while a write is pending.
REQ-007 The block SHALL have port MemRead, input, 1 bit: read request level.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: write request level.
REQ-009 The block SHALL have port mem_data_out, output, 32 bits: read data returned to the CPU.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: single-cycle response strobe.
REQ-011 The block SHALL have port mem_err, output, 1 bit: error flag, valid only while mem_ready=1.
REQ-012 The block SHALL have port led, output, 8 bits: memory-mapped output register.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, if MemRead or MemWrite is 1 at a rising edge, the block SHALL latch the address, write data and request type, and move to WAIT (WAIT_CYCLES>0) or to RESP (WAIT_CYCLES=0).
REQ-015 In WAIT, a 4-bit counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0 the FSM SHALL move to RESP.
REQ-016 In RESP, mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency: for a request sampled at edge N, mem_ready SHALL be high during cycle N+1+WAIT_CYCLES.
REQ-018 Back-to-back: a request still asserted in the IDLE cycle after RESP SHALL be accepted as a new transaction (minimum one IDLE cycle between responses); the CPU drops its request after mem_ready when it has no new one.
REQ-019 Changes on mem_addr, mem_data_in, MemRead or MemWrite outside IDLE SHALL be ignored.
REQ-020 Address map: word RAM at 0x0000_0000 to 4*2^ADDR_W-1, indexed by mem_addr[ADDR_W+1:2].
REQ-021 Address map: led at 0xFFFF_FF00 (R/W, bits [7:0], upper bits read 0).
REQ-022 Address map: a free-running 32-bit cycle counter at 0xFFFF_FF04 (read-only; writes are ignored without error); it increments every cycle and wraps 0xFFFF_FFFF to 0.
REQ-023 An error SHALL be flagged if MemRead and MemWrite are both 1 at acceptance, mem_addr[1:0]!=0, or the address is unmapped.
REQ-024 On error, mem_ready and mem_err SHALL both be 1, no storage SHALL change, and mem_data_out SHALL be 0xDEAD_BEEF.
REQ-025 A write SHALL update the RAM word or led on the edge that enters RESP; mem_data_out SHALL keep its previous value on a successful write.
REQ-026 A read SHALL load mem_data_out on the edge that enters RESP; the value SHALL be held until the next response.
REQ-027 A counter read SHALL return the counter value at the edge entering RESP.
REQ-028 RAM contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-029 While reset=0, the block SHALL force state=IDLE, mem_ready=0, mem_err=0, mem_data_out=0, led=0 and cycle counter=0, asynchronously.
REQ-030 Reset asserted in WAIT SHALL abort the transaction: no write, no mem_ready.
REQ-031 After reset release, the first rising edge SHALL sample requests normally.

Verification
REQ-032 Scenario: WAIT_CYCLES=2, write 0x1234_5678 to 0x10 at edge N, then read 0x10 -> write mem_ready in cycle N+3 with mem_err=0; read returns 0x1234_5678.
REQ-033 Scenario: WAIT_CYCLES=0, hold MemRead on 0x4 continuously -> mem_ready pulses every second cycle and never two cycles in a row.
REQ-034 Scenario: read from 0x6, then read from 0x0001_0000 -> each gives mem_ready=1, mem_err=1, mem_data_out=0xDEAD_BEEF, and RAM is unchanged.
REQ-035 Scenario: MemRead=MemWrite=1 to 0xFFFF_FF00 with data 0xA5 -> mem_err=1 and led stays 0x00; a following plain write of 0xA5 gives led=0xA5.
REQ-036 Scenario: write 0xFFFF_FFFF to 0x20, start a write of 0 to 0x20, pulse reset low during WAIT -> no mem_ready; a later read of 0x20 returns 0xFFFF_FFFF and led=0.
REQ-037 Scenario: two reads of 0xFFFF_FF04 issued K cycles apart -> the returned values differ by exactly K.
